// File: rtl/delay_ctrl_pkg.sv
// Shared types and helpers for the delay-line reconfiguration controller.
package delay_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_LOAD  = 2'd3
   } state_e;

   localparam int unsigned DW_DEF = 32'd4;

   // Total number of cycles a sample spends in the line for a given delay select.
   function automatic int unsigned lat(input int unsigned d, input int unsigned line_lat);
      return d + line_lat;
   endfunction

endpackage

// File: rtl/delay_ctrl_cnt.sv
// Loadable down-counter used to time the DRAIN and FILL phases.
// last_o flags the final cycle of a count (value 1, or 0 for an empty count).
module delay_ctrl_cnt #(
   parameter int unsigned CW      = 32'd6,
   parameter int unsigned RST_VAL = 32'd0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          dec_i,
   output logic          zero_o,
   output logic          last_o
);

   localparam logic [CW-1:0] ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != ZERO)) begin
         cnt_d = cnt_q - ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= CW'(RST_VAL);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == ZERO);
   assign last_o = (cnt_q <= ONE);

endmodule

// File: rtl/delay_line_ctrl.sv
// Sequences run-time delay changes of an external variable delay line:
// drain in-flight samples, switch the delay select, refill, then resume.
module delay_line_ctrl
   import delay_ctrl_pkg::*;
#(
   parameter int unsigned DW        = DW_DEF,
   parameter int unsigned LINE_LAT  = 32'd1,
   parameter int unsigned DEF_DELAY = 32'd0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [DW-1:0] cfg_delay_i,
   input  logic          cfg_valid_i,
   output logic          cfg_ready_o,
   output logic          cfg_done_o,
   input  logic          data_i,
   output logic          in_ready_o,
   output logic          data_o,
   output logic          data_valid_o,
   output logic          busy_o,
   output logic          line_data_o,
   output logic [DW-1:0] line_delay_o,
   input  logic          line_data_i
);

   localparam int unsigned CW = DW + 32'd2;

   state_e        state_q, state_d;
   logic [DW-1:0] line_delay_q, line_delay_d;
   logic [DW-1:0] nxt_delay_q, nxt_delay_d;
   logic          from_load_q, from_load_d;
   logic          cfg_done_q, cfg_done_d;

   logic          cnt_load_s;
   logic          cnt_dec_s;
   logic [CW-1:0] cnt_val_s;
   logic          cnt_zero_s;
   logic          cnt_last_s;
   logic          cfg_acc_s;
   logic          cfg_same_s;

   delay_ctrl_cnt #(
      .CW      (CW),
      .RST_VAL (lat(DEF_DELAY, LINE_LAT))
   ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (cnt_load_s),
      .load_val_i (cnt_val_s),
      .dec_i      (cnt_dec_s),
      .zero_o     (cnt_zero_s),
      .last_o     (cnt_last_s)
   );

   // A request arriving together with reset must not be acknowledged.
   assign cfg_ready_o = (state_q == ST_RUN) && !rst_i;
   assign cfg_acc_s   = cfg_valid_i && cfg_ready_o;
   assign cfg_same_s  = (cfg_delay_i == line_delay_q);

   always_comb begin
      state_d      = state_q;
      line_delay_d = line_delay_q;
      nxt_delay_d  = nxt_delay_q;
      from_load_d  = from_load_q;
      cfg_done_d   = 1'b0;
      cnt_load_s   = 1'b0;
      cnt_dec_s    = 1'b0;
      cnt_val_s    = CW'(lat(32'(line_delay_q), LINE_LAT));
      case (state_q)
         ST_FILL: begin
            cnt_dec_s = 1'b1;
            if (cnt_last_s) begin
               state_d     = ST_RUN;
               cfg_done_d  = from_load_q;
               from_load_d = 1'b0;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_RUN: begin
            if (cfg_acc_s && cfg_same_s) begin
               cfg_done_d = 1'b1;
            end else if (cfg_acc_s) begin
               nxt_delay_d = cfg_delay_i;
               cnt_load_s  = 1'b1;
               state_d     = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            cnt_dec_s = 1'b1;
            if (cnt_last_s) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_LOAD: begin
            line_delay_d = nxt_delay_q;
            cnt_load_s   = 1'b1;
            cnt_val_s    = CW'(lat(32'(nxt_delay_q), LINE_LAT));
            from_load_d  = 1'b1;
            state_d      = ST_FILL;
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_FILL;
         line_delay_q <= DW'(DEF_DELAY);
         nxt_delay_q  <= DW'(DEF_DELAY);
         from_load_q  <= 1'b0;
         cfg_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         line_delay_q <= line_delay_d;
         nxt_delay_q  <= nxt_delay_d;
         from_load_q  <= from_load_d;
         cfg_done_q   <= cfg_done_d;
      end
   end

   // An empty drain (zero total latency) still takes a cycle but carries no sample.
   assign in_ready_o   = (state_q == ST_FILL) || (state_q == ST_RUN);
   assign busy_o       = (state_q != ST_RUN);
   assign data_valid_o = (state_q == ST_RUN) || ((state_q == ST_DRAIN) && !cnt_zero_s);
   assign line_data_o  = data_i & in_ready_o;
   assign line_delay_o = line_delay_q;
   assign data_o       = line_data_i;
   assign cfg_done_o   = cfg_done_q;

endmodule
